// File: rtl/rc4_decrypt_ctrl.sv
// RC4 decrypt controller: requests KSA, then one keystream byte per ciphertext byte, XORs and streams plaintext.
// Optional RC4-drop[n] mode is built in when the RC4_DROP_EN macro is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for start_i; msg_len_i latched on start
// KSA_REQ   | one-cycle genStateArr_o pulse
// KSA_WAIT  | waiting for sarrGenerated_i
// DROP_REQ  | one-cycle genVal_o pulse for a discarded byte (RC4_DROP_EN)
// DROP_WAIT | waiting for the discarded byte (RC4_DROP_EN)
// KS_REQ    | one-cycle genVal_o pulse for the next keystream byte
// KS_WAIT   | waiting for valReady_i; keystream byte latched
// CIPHER    | accepting one ciphertext byte
// OUT       | plaintext byte held until plain_ready_i
// DONE      | one-cycle done_o pulse

module rc4_decrypt_ctrl #(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned DROP_N = 256
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    input  logic             cipher_valid_i,
    input  logic [7:0]       cipher_data_i,
    output logic             cipher_ready_o,
    output logic             plain_valid_o,
    output logic [7:0]       plain_data_o,
    input  logic             plain_ready_i,
    output logic             genStateArr_o,
    input  logic             sarrGenerated_i,
    output logic             genVal_o,
    input  logic             valReady_i,
    input  logic [7:0]       keystream_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] byte_cnt_o
);

    typedef enum logic [3:0] {
        IDLE,
        KSA_REQ,
        KSA_WAIT,
`ifdef RC4_DROP_EN
        DROP_REQ,
        DROP_WAIT,
`endif
        KS_REQ,
        KS_WAIT,
        CIPHER,
        OUT,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_nxt;
    logic [7:0]       ks_q;
    logic [7:0]       plain_q;
    logic             plain_vld_q;
    logic             last_byte;

    assign cnt_nxt   = cnt_q + LEN_W'(1);
    assign last_byte = (cnt_nxt == len_q);

`ifdef RC4_DROP_EN
    localparam int unsigned DROP_W = (DROP_N < 2) ? 1 : $clog2(DROP_N + 1);

    // down-counter of discarded bytes still to be received
    logic [DROP_W-1:0] drop_q;
    logic              last_drop;

    assign last_drop = (drop_q == DROP_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        genStateArr_o  = 1'b0;
        genVal_o       = 1'b0;
        cipher_ready_o = 1'b0;
        done_o         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (msg_len_i == '0) ? DONE : KSA_REQ;
                end
            end
            KSA_REQ: begin
                genStateArr_o = 1'b1;
                state_d       = KSA_WAIT;
            end
            KSA_WAIT: begin
                if (sarrGenerated_i) begin
`ifdef RC4_DROP_EN
                    state_d = (DROP_N == 0) ? KS_REQ : DROP_REQ;
`else
                    state_d = KS_REQ;
`endif
                end
            end
`ifdef RC4_DROP_EN
            DROP_REQ: begin
                genVal_o = 1'b1;
                state_d  = DROP_WAIT;
            end
            DROP_WAIT: begin
                if (valReady_i) begin
                    state_d = last_drop ? KS_REQ : DROP_REQ;
                end
            end
`endif
            KS_REQ: begin
                genVal_o = 1'b1;
                state_d  = KS_WAIT;
            end
            KS_WAIT: begin
                if (valReady_i) begin
                    state_d = CIPHER;
                end
            end
            CIPHER: begin
                cipher_ready_o = 1'b1;
                if (cipher_valid_i) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (plain_ready_i) begin
                    state_d = last_byte ? DONE : KS_REQ;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            len_q       <= '0;
            cnt_q       <= '0;
            ks_q        <= '0;
            plain_q     <= '0;
            plain_vld_q <= 1'b0;
`ifdef RC4_DROP_EN
            drop_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q <= msg_len_i;
                        cnt_q <= '0;
                    end
                end
`ifdef RC4_DROP_EN
                KSA_WAIT: begin
                    if (sarrGenerated_i) begin
                        drop_q <= DROP_W'(DROP_N);
                    end
                end
                DROP_WAIT: begin
                    if (valReady_i) begin
                        drop_q <= drop_q - DROP_W'(1);
                    end
                end
`endif
                KS_WAIT: begin
                    if (valReady_i) begin
                        ks_q <= keystream_i;
                    end
                end
                CIPHER: begin
                    if (cipher_valid_i) begin
                        plain_q     <= cipher_data_i ^ ks_q;
                        plain_vld_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (plain_ready_i) begin
                        plain_vld_q <= 1'b0;
                        cnt_q       <= cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign plain_valid_o = plain_vld_q;
    assign plain_data_o  = plain_q;
    assign byte_cnt_o    = cnt_q;

endmodule

// File: tb/tb_rc4_decrypt_ctrl.sv
// Bench for rc4_decrypt_ctrl: RC4 generator model with key "Key", ciphertext source, plaintext sink and scoreboard.
module tb_rc4_decrypt_ctrl;

`ifdef RC4_DROP_EN
    localparam int DROPN    = 4;
    localparam int DUT_DROP = 4;
`else
    localparam int DROPN    = 0;
    localparam int DUT_DROP = 256;
`endif
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [LW-1:0] msg_len_i = '0;
    logic          cipher_valid_i = 1'b0;
    logic [7:0]    cipher_data_i = 8'h00;
    logic          cipher_ready_o;
    logic          plain_valid_o;
    logic [7:0]    plain_data_o;
    logic          plain_ready_i = 1'b0;
    logic          genStateArr_o;
    logic          sarrGenerated_i = 1'b0;
    logic          genVal_o;
    logic          valReady_i = 1'b0;
    logic [7:0]    keystream_i = 8'h00;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] byte_cnt_o;

    rc4_decrypt_ctrl #(.LEN_W(LW), .DROP_N(DUT_DROP)) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .msg_len_i(msg_len_i),
        .cipher_valid_i(cipher_valid_i), .cipher_data_i(cipher_data_i), .cipher_ready_o(cipher_ready_o),
        .plain_valid_o(plain_valid_o), .plain_data_o(plain_data_o), .plain_ready_i(plain_ready_i),
        .genStateArr_o(genStateArr_o), .sarrGenerated_i(sarrGenerated_i),
        .genVal_o(genVal_o), .valReady_i(valReady_i), .keystream_i(keystream_i),
        .busy_o(busy_o), .done_o(done_o), .byte_cnt_o(byte_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // keystream for key "Key" from the plain RC4 definition
    logic [7:0] ks_ref [128];
    logic [7:0] kv_cipher [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] kv_plain  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    function automatic void build_ks();
        int s [256];
        int key [3];
        int i, j, t;
        key = '{75, 101, 121};
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + key[n % 3]) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 0; n < 128; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_ref[n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endfunction

    // generator model
    int gen_lat = 1;
    int ksa_lat = 2;
    int val_pend = 0;
    int ksa_pend = 0;
    int ks_idx = 0;
    bit stray_en = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            sarrGenerated_i = 1'b0;
            valReady_i = 1'b0;
            if (ksa_pend > 0) begin
                ksa_pend--;
                if (ksa_pend == 0) sarrGenerated_i = 1'b1;
            end
            if (val_pend > 0) begin
                val_pend--;
                if (val_pend == 0) begin
                    valReady_i = 1'b1;
                    keystream_i = ks_idx < 128 ? ks_ref[ks_idx] : 8'h00;
                    ks_idx++;
                end
            end else if (stray_en && plain_valid_o) begin
                valReady_i = 1'b1;
                keystream_i = 8'h5A;
            end
            if (genStateArr_o) begin
                ksa_pend = ksa_lat;
                val_pend = 0;
                ks_idx = 0;
            end
            if (genVal_o) val_pend = gen_lat;
        end
    end

    // ciphertext source
    int cv_mode = 0;
    logic [7:0] cq [$];

    initial begin : src
        bit fire;
        forever begin
            @(negedge clk);
            fire = cipher_valid_i && cipher_ready_o;
            @(posedge clk); #1;
            if (fire && cq.size() > 0) void'(cq.pop_front());
            case (cv_mode)
                0:       cipher_valid_i = cq.size() > 0;
                1:       cipher_valid_i = (cq.size() > 0) && cipher_ready_o;
                default: cipher_valid_i = (cq.size() > 0) && ($urandom_range(0, 1) == 1);
            endcase
            cipher_data_i = cq.size() > 0 ? cq[0] : 8'h00;
        end
    end

    // plaintext sink; mode 2 stalls byte index 2 for five cycles
    int rd_mode = 0;
    logic [7:0] got [$];

    initial begin : snk
        int scnt;
        scnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!busy_o) scnt = 0;
            case (rd_mode)
                0: plain_ready_i = 1'b1;
                1: plain_ready_i = ($urandom_range(0, 1) == 1);
                default: begin
                    if (plain_valid_o && got.size() == 2 && scnt < 5) begin
                        plain_ready_i = 1'b0;
                        scnt++;
                    end else begin
                        plain_ready_i = 1'b1;
                    end
                end
            endcase
        end
    end

    // monitor
    int n_ksa = 0, n_val = 0, n_done = 0, n_stall = 0, outst = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                outst = 0;
                prev_stall = 1'b0;
            end else begin
                if (genStateArr_o) n_ksa++;
                if (genVal_o) begin
                    check("one_outstanding_request", outst, 0);
                    outst = 1;
                    n_val++;
                end else if (valReady_i) begin
                    outst = 0;
                end
                if (done_o) n_done++;
                if (prev_stall) begin
                    check("stall_valid_hold", plain_valid_o, 1);
                    check("stall_data_hold", plain_data_o, prev_data);
                end
                if (plain_valid_o && !plain_ready_i) begin
                    n_stall++;
                    check("stall_no_genval", genVal_o, 0);
                    check("stall_no_cipher_ready", cipher_ready_o, 0);
                    prev_stall = 1'b1;
                    prev_data = plain_data_o;
                end else begin
                    prev_stall = 1'b0;
                end
                if (plain_valid_o && plain_ready_i) got.push_back(plain_data_o);
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {2'b00, cipher_ready_o, plain_valid_o, plain_data_o, genStateArr_o, genVal_o,
                busy_o, done_o, byte_cnt_o};
    endfunction

    task automatic run_msg(input string tag, input int len, input int lat, input int cvm, input int rdm,
                           input bit known, input int e_ksa, input int e_val, input int e_cnt);
        logic [7:0] exp [$];
        logic [7:0] c;
        int k0, v0, d0, s0, cyc;
        gen_lat = lat; cv_mode = cvm; rd_mode = rdm;
        got.delete(); cq.delete();
        for (int k = 0; k < len; k++) begin
            c = known ? kv_cipher[k] : 8'($urandom_range(0, 255));
            cq.push_back(c);
`ifdef RC4_DROP_EN
            exp.push_back(c ^ ks_ref[DROPN + k]);
`else
            exp.push_back(known ? kv_plain[k] : c ^ ks_ref[k]);
`endif
        end
        k0 = n_ksa; v0 = n_val; d0 = n_done; s0 = n_stall;
        @(posedge clk); #1;
        start_i = 1'b1; msg_len_i = LW'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (n_done == d0 && cyc < 200 + (len + DROPN) * 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_count"}, n_done - d0, 1);
        @(posedge clk); #1;
        check({tag, "_busy_after_done"}, busy_o, 0);
        check({tag, "_byte_cnt"}, byte_cnt_o, e_cnt);
        check({tag, "_num_bytes"}, got.size(), len);
        for (int k = 0; k < len && k < got.size(); k++) check({tag, "_plain_byte"}, got[k], exp[k]);
        check({tag, "_ksa_pulses"}, n_ksa - k0, e_ksa);
        check({tag, "_genval_pulses"}, n_val - v0, e_val);
        if (rdm == 2 && len >= 3) check({tag, "_stall_cycles"}, n_stall - s0, 5);
    endtask

    typedef struct {
        int len; int lat; int cvm; int rdm;
        int e_ksa; int e_val; int e_cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, v0, cyc, len, lat;
        build_ks();
        tbl[0] = '{1, 1, 0, 0, 1, 1 + DROPN, 1};
        tbl[1] = '{2, 3, 2, 1, 1, 2 + DROPN, 2};
        tbl[2] = '{5, 1, 1, 1, 1, 5 + DROPN, 5};
        tbl[3] = '{16, 4, 2, 1, 1, 16 + DROPN, 16};
        tbl[4] = '{3, 6, 0, 2, 1, 3 + DROPN, 3};
        tbl[5] = '{1, 7, 1, 0, 1, 1 + DROPN, 1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 0);
        rst_i = 1'b0;

        run_msg("kv_lat1_early", 9, 1, 0, 0, 1, 1, 9 + DROPN, 9);
        stray_en = 1'b1;
        run_msg("kv_lat7_late_stray", 9, 7, 1, 0, 1, 1, 9 + DROPN, 9);
        stray_en = 1'b0;
        run_msg("kv_backpressure", 9, 2, 0, 2, 1, 1, 9 + DROPN, 9);

        // zero-length message
        k0 = n_ksa; v0 = n_val;
        @(posedge clk); #1;
        start_i = 1'b1; msg_len_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("zero_len_done_high", done_o, 1);
        check("zero_len_busy_in_done", busy_o, 1);
        @(posedge clk); #1;
        check("zero_len_done_low", done_o, 0);
        check("zero_len_busy_low", busy_o, 0);
        check("zero_len_no_ksa", n_ksa - k0, 0);
        check("zero_len_no_genval", n_val - v0, 0);

        // start while busy is ignored
        fork
            run_msg("busy_start", 4, 2, 0, 0, 0, 1, 4 + DROPN, 4);
            begin
                repeat (3) @(posedge clk);
                #1;
                start_i = 1'b1; msg_len_i = LW'(9);
                @(posedge clk); #1;
                start_i = 1'b0;
            end
        join

        // reset while waiting for the third keystream byte
        gen_lat = 8; cv_mode = 0; rd_mode = 0;
        got.delete(); cq.delete();
        for (int k = 0; k < 5; k++) cq.push_back(8'($urandom_range(0, 255)));
        @(posedge clk); #1;
        start_i = 1'b1; msg_len_i = LW'(5);
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (got.size() < 2 && cyc < 1000) begin @(negedge clk); cyc++; end
        check("reset_seq_two_bytes", got.size(), 2);
        v0 = n_val; cyc = 0;
        while (n_val == v0 && cyc < 100) begin @(negedge clk); cyc++; end
        check("reset_seq_third_request", n_val - v0, 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("midmsg_reset_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        cq.delete();
        check("midmsg_reset_release_outputs", all_outs(), 0);
        repeat (12) @(posedge clk);
        #1;
        check("late_valready_in_idle_ignored", all_outs(), 0);

        foreach (tbl[i]) begin
            run_msg("table", tbl[i].len, tbl[i].lat, tbl[i].cvm, tbl[i].rdm, 0,
                    tbl[i].e_ksa, tbl[i].e_val, tbl[i].e_cnt);
        end

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 20);
            lat = $urandom_range(1, 7);
            run_msg("random", len, lat, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1, len + DROPN, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
